// File: rtl/ofifo_collect.sv
// ofifo_collect: per-column psum FIFO lanes presenting complete rows first-word-fall-through
module ofifo_collect #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16,
  parameter int ptr_w   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);
  logic [col-1:0] empty, full, we, drop;
  logic pop;
  assign o_valid = ~|empty;
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign pop     = rd & o_valid;
  genvar g;
  for (g = 0; g < col; g++) begin : lane
    logic [ptr_w:0] wptr, rptr;
    logic [bw_psum-1:0] mem [depth];
    assign empty[g] = wptr == rptr;
    assign full[g]  = (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]) & (wptr[ptr_w] != rptr[ptr_w]);
    // a full lane frees its head slot when the row pops in the same cycle
    assign we[g]    = wr[g] & (~full[g] | pop);
    assign drop[g]  = wr[g] & full[g] & ~pop;
    always_ff @(posedge clk)
      if (we[g]) mem[wptr[ptr_w-1:0]] <= in[g*bw_psum +: bw_psum];
    always_ff @(posedge clk) begin
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (we[g]) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
      end
    end
    assign out[g*bw_psum +: bw_psum] = o_valid ? mem[rptr[ptr_w-1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) o_overflow <= 1'b0;
    else if (|drop) o_overflow <= 1'b1;
  end
endmodule

// File: tb/tb_ofifo_collect.sv
// tb_ofifo_collect: directed self-checking bench for ofifo_collect
module tb_ofifo_collect;
  localparam int W = 8 * 22;
  logic clk = 0, reset = 0, rd = 0;
  logic [W-1:0] in = '0, out, v;
  logic [7:0] wr = '0;
  logic o_valid, o_full, o_ready, o_overflow;
  int checks = 0, errors = 0;

  ofifo_collect dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int base);
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*22 +: 22] = 22'(base + i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [7:0] w, input logic [W-1:0] d, input logic r);
    wr = w; in = d; rd = r;
    @(posedge clk); #1;
    wr = '0; rd = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc('0, '0, 0);
    reset = 0;
  endtask

  initial begin
    do_reset();
    check("rst_valid", o_valid, 0);
    check("rst_full", o_full, 0);
    check("rst_ready", o_ready, 1);
    check("rst_ovf", o_overflow, 0);
    check("rst_out", out, '0);

    cyc(8'hFF, mk(1), 0);
    check("row1_valid", o_valid, 1);
    check("row1_out", out, mk(1));
    cyc('0, '0, 1);
    check("row1_pop_valid", o_valid, 0);
    check("row1_pop_out", out, '0);
    cyc('0, '0, 1);
    check("rd_empty_valid", o_valid, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(8'(1 << i), mk(100), 0);
      check($sformatf("stag_valid_%0d", i), o_valid, (i == 7) ? 1 : 0);
    end
    check("stag_out", out, mk(100));
    cyc('0, '0, 1);
    check("stag_pop_valid", o_valid, 0);

    for (int r = 0; r < 16; r++) cyc(8'hFF, mk(16 * r), 0);
    check("fill_full", o_full, 1);
    check("fill_ready", o_ready, 0);
    check("fill_valid", o_valid, 1);
    check("fill_ovf0", o_overflow, 0);
    cyc(8'hFF, mk(999), 0);
    check("ovf_set", o_overflow, 1);
    check("ovf_head", out, mk(0));
    check("ovf_full", o_full, 1);
    for (int r = 0; r < 16; r++) begin
      check($sformatf("drain_%0d", r), out, mk(16 * r));
      cyc('0, '0, 1);
    end
    check("drain_valid", o_valid, 0);
    check("drain_full", o_full, 0);
    check("ovf_sticky", o_overflow, 1);

    do_reset();
    check("rst2_ovf", o_overflow, 0);
    for (int r = 0; r < 16; r++) cyc(8'hFF, mk(16 * r), 0);
    cyc(8'hFF, mk(500), 1);
    check("wrpop_ovf", o_overflow, 0);
    check("wrpop_full", o_full, 1);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wrpop_drain_%0d", k), out, (k < 15) ? mk(16 * (k + 1)) : mk(500));
      cyc('0, '0, 1);
    end
    check("wrpop_empty", o_valid, 0);

    for (int i = 0; i < 8; i++) v[i*22 +: 22] = (i % 2 == 0) ? 22'h200000 : 22'h1FFFFF;
    cyc(8'hFF, v, 0);
    check("signed_out", out, v);
    check("signed_msb", out[21], 1);
    cyc(8'hFF, mk(7), 1);
    check("occ1_wrpop_out", out, mk(7));
    check("occ1_wrpop_valid", o_valid, 1);
    cyc('0, '0, 1);
    check("occ1_empty", o_valid, 0);

    for (int r = 0; r < 16; r++) cyc(8'hFF, mk(16 * r), 0);
    cyc(8'hFF, mk(999), 0);
    for (int k = 0; k < 11; k++) cyc('0, '0, 1);
    check("pre_rst_head", out, mk(176));
    check("pre_rst_ovf", o_overflow, 1);
    reset = 1;
    cyc(8'hFF, mk(300), 1);
    reset = 0;
    check("midrst_valid", o_valid, 0);
    check("midrst_full", o_full, 0);
    check("midrst_ovf", o_overflow, 0);
    check("midrst_out", out, '0);
    cyc(8'hFF, mk(42), 0);
    check("postrst_valid", o_valid, 1);
    check("postrst_out", out, mk(42));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofifo_collect.md
Name: ofifo_collect

Overview:
- Output collector sitting directly downstream of the MAC column array.
- Holds one FIFO lane per column; each lane captures that column's psum when the column's fifo_wr strobe is high.
- Columns finish at staggered times, so lanes fill out of step with each other.
- A full row (one psum from every column) is presented to the readout/SFU stage first-word-fall-through and popped as a unit.

Parameters:
- col, 8, number of MAC columns / FIFO lanes
- bw_psum, 22, psum width per column (2*bw+6 with bw=8)
- depth, 16, entries per lane, power of two
- ptr_w, 4, log2(depth)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in  input  col*bw_psum  packed column psums; lane i uses bits [(i+1)*bw_psum-1 : i*bw_psum]
- wr  input  col  per-lane write strobe, bit i = fifo_wr of column i
- rd  input  1  pop one full row
- out  output  col*bw_psum  head row, packed the same way as in
- o_valid  output  1  every lane non-empty; out is a complete row
- o_full  output  1  at least one lane full
- o_ready  output  1  equals ~o_full
- o_overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Storage and pointers
  - Each lane is a depth-entry register array.
  - Write and read pointers are ptr_w+1 bits wide; the MSB is the wrap bit.
  - Lane empty: the pointers are equal.
  - Lane full: the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*depth.
- Reset (synchronous, on a clk edge while reset=1)
  - All pointers go to 0 and o_overflow goes to 0.
  - Outputs the cycle after reset: o_valid=0, o_full=0, o_ready=1, out=0.
  - Memory contents need not be cleared.
  - Reset mid-operation discards all stored data. A wr or rd in the reset cycle is ignored.
- Pop rule
  - pop = rd & o_valid.
  - rd while o_valid=0 is ignored: no pointer moves and no error is flagged.
- Write rule, per lane i
  - Write accepted if wr[i] & (~full_i | pop). A full lane still accepts a write when the same cycle pops.
  - Accepted: mem_i[wptr_i] <= in slice i, then wptr_i increments.
  - wr[i] on a full lane with no pop: data is dropped, the pointer holds, and o_overflow <= 1.
  - o_overflow clears only on reset.
- Read rule
  - On pop, every lane's rptr increments in the same cycle.
- Simultaneous write and pop on one lane
  - Both take effect and the occupancy is unchanged.
  - The write lands in the slot at wptr. The head moves to rptr+1.
  - A lane with occupancy 1 that is written and popped in the same cycle presents the new data as head the next cycle.
- Output timing
  - out is combinational from the head entries, first-word-fall-through.
  - out is forced to 0 whenever o_valid=0.
  - Write-to-visible latency: data written at edge t appears on out after edge t if it completes the row. No same-cycle bypass.
- Flags
  - o_valid, o_full and o_ready are combinational from the pointers, registered state only.
  - They update the cycle after the causing edge.
- Width: psums are stored and forwarded bit-exact, with no sign extension or truncation.
- Fill asymmetry: lanes may hold different occupancies. o_valid follows the emptiest lane and o_full follows the fullest lane.

Test Plan:
- Reset, then write all 8 lanes in one cycle with lane i = i+1 -> next cycle o_valid=1 and out lanes read 1..8; pulse rd -> o_valid=0 and out=0.
- Staggered fill: wr[i] asserted at cycle i for i=0..7 -> o_valid stays 0 through cycle 7 and rises the cycle after lane 7's write; values in order.
- Fill all lanes with 16 rows (row r, lane i = 16*r+i) -> o_full=1, o_ready=0; a 17th wr without rd -> o_overflow=1 and the FIFO is unchanged; drain 16 pops -> rows 0..15 in order, then o_valid=0.
- With all lanes full, wr all and rd in the same cycle -> no overflow, o_full stays 1; after 16 further pops the last row out is the simultaneously written row.
- Signed boundary: write -2097152 (0x200000) and 2097151 (0x1FFFFF) in alternating lanes -> read back bit-exact; negative psum sign preserved.
- Assert reset with 5 rows stored and rd high in the same cycle -> next cycle o_valid=0, o_full=0, o_overflow=0, out=0; a new write then appears as head.
